// File: rtl/sipo_rx_ctrl_if.sv
// ============================================================================
// Module      : sipo_rx_ctrl_if
// Description : Bundles serial front-end, SIPO and parallel-consumer signals
//               of the SIPO receive controller. Parity signals exist only
//               when SIPO_PARITY_CHK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sipo_rx_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             frame_start;
    logic             bit_stb;
    logic [WIDTH-1:0] sipo_pout;
    logic             sipo_shift;
    logic             sipo_clr;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;
`ifdef SIPO_PARITY_CHK_EN
    logic             par_bit;
    logic             parity_err;
`endif

    // master: the controller; slave: front end, SIPO and consumer side
    modport master (
        input  frame_start, bit_stb, sipo_pout, out_ready,
`ifdef SIPO_PARITY_CHK_EN
        input  par_bit,
        output parity_err,
`endif
        output sipo_shift, sipo_clr, out_data, out_valid, busy, overrun, frame_err
    );

    modport slave (
        output frame_start, bit_stb, sipo_pout, out_ready,
`ifdef SIPO_PARITY_CHK_EN
        output par_bit,
        input  parity_err,
`endif
        input  sipo_shift, sipo_clr, out_data, out_valid, busy, overrun, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/sipo_rx_ctrl.sv
// ============================================================================
// Module      : sipo_rx_ctrl
// Description : Frames WIDTH serial bits into the SIPO and hands the captured
//               word out on a valid/ready port. Optional even-parity check
//               enabled by defining SIPO_PARITY_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_rx_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire               clk,
    input  wire               reset,
    sipo_rx_ctrl_if.master    bus
);

`ifdef SIPO_PARITY_CHK_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PARITY  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;
`endif

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_overrun;
    logic               r_frame_err;
    logic               w_shift;
    logic               w_clr;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_abort;
    logic               w_load;
`ifdef SIPO_PARITY_CHK_EN
    logic               w_par_sample;
    logic               r_par_bit_q;
    logic               r_parity_err;
`endif

    always_comb begin
        w_next_state = r_state;
        w_shift      = 1'b0;
        w_clr        = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_abort      = 1'b0;
`ifdef SIPO_PARITY_CHK_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    w_clr        = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A new frame_start wins over a coinciding strobe
                if (bus.frame_start) begin
                    w_clr     = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_abort   = 1'b1;
                end else if (bus.bit_stb) begin
                    w_shift   = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (r_cnt == C_LAST) begin
`ifdef SIPO_PARITY_CHK_EN
                        w_next_state = ST_PARITY;
`else
                        w_next_state = ST_CAPTURE;
`endif
                    end
                end
            end
`ifdef SIPO_PARITY_CHK_EN
            ST_PARITY: begin
                if (bus.frame_start) begin
                    w_clr        = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_abort      = 1'b1;
                    w_next_state = ST_SHIFT;
                end else if (bus.bit_stb) begin
                    w_par_sample = 1'b1;
                    w_next_state = ST_CAPTURE;
                end
            end
`endif
            ST_CAPTURE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
        if (reset) begin
            w_shift = 1'b0;
            w_clr   = 1'b0;
        end
    end

    // Holding register accepts a new word when empty or drained this cycle
    assign w_load = (r_state == ST_CAPTURE) && (!r_out_valid || bus.out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_frame_err <= w_abort;
            if (w_cnt_clr)
                r_cnt <= '0;
            else if (w_cnt_inc)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_load) begin
                r_out_data  <= bus.sipo_pout;
                r_out_valid <= 1'b1;
            end else begin
                if (r_state == ST_CAPTURE)
                    r_overrun <= 1'b1;
                if (r_out_valid && bus.out_ready)
                    r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_bit_q  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_sample)
                r_par_bit_q <= bus.par_bit;
            if (w_load)
                r_parity_err <= (^bus.sipo_pout) ^ r_par_bit_q;
        end
    end

    assign bus.parity_err = r_parity_err;
`endif

    assign bus.sipo_shift = w_shift;
    assign bus.sipo_clr   = w_clr;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.overrun    = r_overrun;
    assign bus.frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx_ctrl.sv
// ============================================================================
// Module      : tb_sipo_rx_ctrl
// Description : Directed self-checking bench for sipo_rx_ctrl with a
//               behavioural 8-bit MSB-first SIPO attached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_rx_ctrl;
    localparam int WIDTH = 8;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [7:0] sreg;
    int         shift_cnt;
    int         shift_base;
    int         n_checks;
    int         n_fail;

    sipo_rx_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sipo_rx_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SIPO: sipo_clr drives its synchronous reset
    always @(posedge clk) begin
        if (reset || bus.sipo_clr)
            sreg <= 8'h00;
        else if (bus.sipo_shift)
            sreg <= {sreg[6:0], serial_in};
    end
    assign bus.sipo_pout = sreg;

    initial shift_cnt = 0;
    always @(posedge clk) if (bus.sipo_shift) shift_cnt <= shift_cnt + 1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        #1;
        chk1("clr_at_start", bus.sipo_clr, 1'b1);
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    // Drive n strobes carrying w MSB first, one per cycle
    task automatic send_bits(input logic [7:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            bus.bit_stb = 1'b1;
            serial_in   = w[7-i];
            @(negedge clk);
        end
        bus.bit_stb = 1'b0;
    endtask

    // Parity strobe exists only with the checker built in; send even parity
    task automatic end_word(input logic [7:0] w);
`ifdef SIPO_PARITY_CHK_EN
        bus.par_bit = ^w;
        bus.bit_stb = 1'b1;
        @(negedge clk);
        bus.bit_stb = 1'b0;
`else
        serial_in = w[0];
`endif
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        serial_in       = 1'b0;
        bus.frame_start = 1'b1;
        bus.bit_stb     = 1'b1;
        bus.out_ready   = 1'b1;
`ifdef SIPO_PARITY_CHK_EN
        bus.par_bit     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk1("rst_valid", bus.out_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_overrun", bus.overrun, 1'b0);
        chk1("rst_frame_err", bus.frame_err, 1'b0);
        chk8("rst_data", bus.out_data, 8'h00);
        chk1("rst_clr_low", bus.sipo_clr, 1'b0);
        chk1("rst_shift_low", bus.sipo_shift, 1'b0);
        reset           = 1'b0;
        bus.frame_start = 1'b0;

        // Idle with strobes toggling: nothing may shift
        shift_base = shift_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.bit_stb = i[0];
            serial_in   = 1'b1;
            @(negedge clk);
        end
        bus.bit_stb = 1'b0;
        chk1("idle_valid", bus.out_valid, 1'b0);
        chk1("idle_busy", bus.busy, 1'b0);
        chk1("idle_overrun", bus.overrun, 1'b0);
        chk8("idle_shifts", 8'(shift_cnt - shift_base), 8'd0);

        // Single word 0xA5, consumer ready
        shift_base = shift_cnt;
        start_frame();
        chk1("a5_busy", bus.busy, 1'b1);
        send_bits(8'hA5, 0, 8);
        end_word(8'hA5);
        chk1("a5_capture_no_valid", bus.out_valid, 1'b0);
        chk1("a5_capture_busy", bus.busy, 1'b1);
        @(negedge clk);
        chk1("a5_valid", bus.out_valid, 1'b1);
        chk8("a5_data", bus.out_data, 8'hA5);
        chk1("a5_idle", bus.busy, 1'b0);
        chk8("a5_shifts", 8'(shift_cnt - shift_base), 8'd8);
        @(negedge clk);
        chk1("a5_valid_drop", bus.out_valid, 1'b0);

        // Back-to-back 0xA5, 0x3C with consumer stalled
        bus.out_ready = 1'b0;
        start_frame();
        send_bits(8'hA5, 0, 8);
        end_word(8'hA5);
        @(negedge clk);
        chk1("ovr_first_valid", bus.out_valid, 1'b1);
        chk1("ovr_none_yet", bus.overrun, 1'b0);
        start_frame();
        send_bits(8'h3C, 0, 8);
        end_word(8'h3C);
        @(negedge clk);
        chk8("ovr_data_held", bus.out_data, 8'hA5);
        chk1("ovr_set", bus.overrun, 1'b1);
        chk1("ovr_valid_held", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk1("ovr_accept_drop", bus.out_valid, 1'b0);
        chk1("ovr_sticky", bus.overrun, 1'b1);

        // Abort after 3 bits, then a full 0x5A
        start_frame();
        send_bits(8'hFF, 0, 3);
        bus.frame_start = 1'b1;
        #1;
        chk1("abort_clr", bus.sipo_clr, 1'b1);
        chk1("abort_no_shift", bus.sipo_shift, 1'b0);
        @(negedge clk);
        bus.frame_start = 1'b0;
        chk1("abort_frame_err", bus.frame_err, 1'b1);
        chk1("abort_busy", bus.busy, 1'b1);
        chk1("abort_no_valid", bus.out_valid, 1'b0);
        send_bits(8'h5A, 0, 8);
        chk1("abort_err_pulse", bus.frame_err, 1'b0);
        end_word(8'h5A);
        @(negedge clk);
        chk1("5a_valid", bus.out_valid, 1'b1);
        chk8("5a_data", bus.out_data, 8'h5A);
        @(negedge clk);

        // Strobes coinciding with frame_start are never counted
        shift_base      = shift_cnt;
        serial_in       = 1'b0;
        bus.frame_start = 1'b1;
        bus.bit_stb     = 1'b1;
        #1;
        chk1("coin_idle_clr", bus.sipo_clr, 1'b1);
        chk1("coin_idle_shift", bus.sipo_shift, 1'b0);
        @(negedge clk);
        #1;
        chk1("coin_shift_clr", bus.sipo_clr, 1'b1);
        chk1("coin_shift_shift", bus.sipo_shift, 1'b0);
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.bit_stb     = 1'b0;
        chk1("coin_frame_err", bus.frame_err, 1'b1);
        send_bits(8'hFF, 0, 7);
        repeat (2) @(negedge clk);
        chk1("coin_7_busy", bus.busy, 1'b1);
        chk1("coin_7_no_valid", bus.out_valid, 1'b0);
        send_bits(8'hFF, 7, 1);
        end_word(8'hFF);
        @(negedge clk);
        chk1("ff_valid", bus.out_valid, 1'b1);
        chk8("ff_data", bus.out_data, 8'hFF);
        chk8("ff_shifts", 8'(shift_cnt - shift_base), 8'd8);
        @(negedge clk);

`ifdef SIPO_PARITY_CHK_EN
        for (int p = 0; p < 2; p++) begin
            shift_base = shift_cnt;
            start_frame();
            send_bits(8'hA5, 0, 8);
            bus.par_bit = p[0];
            bus.bit_stb = 1'b1;
            #1;
            chk1("par_no_shift", bus.sipo_shift, 1'b0);
            @(negedge clk);
            bus.bit_stb = 1'b0;
            @(negedge clk);
            chk1("par_valid", bus.out_valid, 1'b1);
            chk1("par_err", bus.parity_err, p[0]);
            chk8("par_shifts", 8'(shift_cnt - shift_base), 8'd8);
            @(negedge clk);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
